// File: rtl/cal_core_sched.sv
// cal_core_sched: row sequencer feeding one cal_core through a decode pass.
// For every check row it reads the H row and the A alpha beats from their
// memories, then streams them to cal_core (H_row + alpha_u_col beats). It waits
// for cal_core to finish each row and sweeps all I rows iter_num times.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, iter_num       pass request (iter_num sampled when start accepted)
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   row_idx, iter_idx     row and iteration being issued or awaited
//   h_rd_en/h_addr/h_rdata  H memory port (1-cycle read latency)
//   a_rd_en/a_addr/a_rdata  alpha memory port (1-cycle read latency)
//   core_ready, core_done   cal_core row handshake
//   H_row*, alpha_u_col*    registered row stream to cal_core
module cal_core_sched #(
  parameter int J        = 14,
  parameter int I        = 7,
  parameter int A        = 2,
  parameter int MAX_ITER = 15,
  parameter int I_WIDTH  = $clog2(I) + 1,
  parameter int A_WIDTH  = $clog2(A) + 1,
  parameter int IT_WIDTH = $clog2(MAX_ITER) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IT_WIDTH-1:0] iter_num,
  output logic                busy,
  output logic                done,
  output logic [I_WIDTH-1:0]  row_idx,
  output logic [IT_WIDTH-1:0] iter_idx,
  output logic                h_rd_en,
  output logic [I_WIDTH-1:0]  h_addr,
  input  logic [J-1:0]        h_rdata,
  output logic                a_rd_en,
  output logic [A_WIDTH-1:0]  a_addr,
  input  logic [J*8-1:0]      a_rdata,
  input  logic                core_ready,
  input  logic                core_done,
  output logic [J-1:0]        H_row,
  output logic                H_row_tvalid,
  output logic [J*8-1:0]      alpha_u_col,
  output logic                alpha_u_col_tvalid,
  output logic                alpha_u_col_tlast
);

  // FIN is the single done cycle; busy is still high there so that done and
  // busy drop together on the following edge.
  typedef enum logic [2:0] {IDLE, WAIT_RDY, FETCH, DRAIN, WAIT_DONE, FIN} state_t;

  state_t              state, state_n;
  logic [I_WIDTH-1:0]  row, row_n;
  logic [IT_WIDTH-1:0] iter, iter_n, iter_max, iter_max_n;
  logic [A_WIDTH-1:0]  k, k_n;

  // vld_pipe[1]: read data is on the memory outputs this cycle
  // vld_pipe[2]: beat is presented on the stream registers
  logic [2:1] vld_pipe;
  logic       last_d1, h_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      iter     <= '0;
      iter_max <= '0;
      k        <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      iter     <= iter_n;
      iter_max <= iter_max_n;
      k        <= k_n;
    end
  end

  always_comb begin
    state_n    = state;
    row_n      = row;
    iter_n     = iter;
    iter_max_n = iter_max;
    k_n        = k;
    case (state)
      IDLE: if (start) begin
        if (iter_num == '0)                          iter_max_n = IT_WIDTH'(1);
        else if (iter_num > IT_WIDTH'(MAX_ITER))     iter_max_n = IT_WIDTH'(MAX_ITER);
        else                                         iter_max_n = iter_num;
        row_n   = '0;
        iter_n  = '0;
        state_n = WAIT_RDY;
      end
      WAIT_RDY: if (core_ready) begin
        k_n     = '0;
        state_n = FETCH;
      end
      FETCH: begin
        if (k == A_WIDTH'(A - 1)) state_n = DRAIN;
        else                      k_n     = k + 1'b1;
      end
      // Leave once the tlast beat is on the stream registers.
      DRAIN: if (vld_pipe[2] && alpha_u_col_tlast) state_n = WAIT_DONE;
      WAIT_DONE: if (core_done) begin
        if (row == I_WIDTH'(I - 1)) begin
          row_n = '0;
          if (iter == iter_max - IT_WIDTH'(1)) begin
            state_n = FIN;
          end else begin
            iter_n  = iter + 1'b1;
            state_n = WAIT_RDY;
          end
        end else begin
          row_n   = row + 1'b1;
          state_n = WAIT_RDY;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign row_idx  = row;
  assign iter_idx = iter;
  assign a_rd_en  = (state == FETCH);
  assign a_addr   = k;
  assign h_rd_en  = (state == FETCH) && (k == '0);
  assign h_addr   = row;

  // Stream registers: load on the edge after rdata is valid. H is only read
  // on beat 0, so H_row is held while the remaining beats go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe          <= '0;
      last_d1           <= 1'b0;
      h_d1              <= 1'b0;
      alpha_u_col_tlast <= 1'b0;
      alpha_u_col       <= '0;
      H_row             <= '0;
    end else begin
      vld_pipe[1]       <= a_rd_en;
      vld_pipe[2]       <= vld_pipe[1];
      last_d1           <= a_rd_en && (k == A_WIDTH'(A - 1));
      h_d1              <= h_rd_en;
      alpha_u_col_tlast <= vld_pipe[1] && last_d1;
      if (vld_pipe[1]) alpha_u_col <= a_rdata;
      if (h_d1)        H_row       <= h_rdata;
    end
  end

  assign alpha_u_col_tvalid = vld_pipe[2];
  assign H_row_tvalid       = vld_pipe[2];

endmodule

// File: tb/tb_cal_core_sched.sv
// Directed bench for cal_core_sched: memory and cal_core responders plus a
// negedge monitor that logs beats, H reads and done pulses for the tests.
module tb_cal_core_sched;
  localparam int J = 14, I = 7, A = 2, MAX_ITER = 15;
  localparam int IW = $clog2(I) + 1, AW = $clog2(A) + 1, TW = $clog2(MAX_ITER) + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [TW-1:0] iter_num = '0;
  logic busy, done, h_rd_en, a_rd_en;
  logic [IW-1:0] row_idx, h_addr;
  logic [TW-1:0] iter_idx;
  logic [AW-1:0] a_addr;
  logic [J-1:0] h_rdata = '0, H_row;
  logic [J*8-1:0] a_rdata = '0, alpha_u_col;
  logic core_ready = 1'b0, auto_done = 1'b0, man_done = 1'b0, core_done;
  logic H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast;
  assign core_done = auto_done | man_done;

  int checks = 0, failures = 0;
  logic [J-1:0]   h_mem [I];
  logic [J*8-1:0] a_mem [A];

  always #5 clk = ~clk;

  cal_core_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iter_num(iter_num),
    .busy(busy), .done(done), .row_idx(row_idx), .iter_idx(iter_idx),
    .h_rd_en(h_rd_en), .h_addr(h_addr), .h_rdata(h_rdata),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .core_ready(core_ready), .core_done(core_done),
    .H_row(H_row), .H_row_tvalid(H_row_tvalid),
    .alpha_u_col(alpha_u_col), .alpha_u_col_tvalid(alpha_u_col_tvalid),
    .alpha_u_col_tlast(alpha_u_col_tlast)
  );

  // synchronous memories, 1-cycle read latency
  always @(posedge clk) begin
    if (h_rd_en) h_rdata <= h_mem[h_addr];
    if (a_rd_en) a_rdata <= a_mem[a_addr];
  end

  // cal_core stand-in: core_done 3 cycles after the tlast beat
  logic auto_en = 1'b0;
  int dly = 0;
  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) auto_done <= 1'b1;
    end else if (auto_en && alpha_u_col_tvalid && alpha_u_col_tlast) begin
      dly <= 3;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int beat_cyc[$];
  logic [J*8-1:0] beat_a[$];
  logic [J-1:0] beat_h[$];
  logic beat_last[$], beat_hv[$];
  int haddr_log[$], iter_log[$];
  int done_cnt = 0, rd_cnt = 0;

  always @(negedge clk) if (rst_n) begin
    if (alpha_u_col_tvalid) begin
      beat_cyc.push_back(cyc); beat_a.push_back(alpha_u_col);
      beat_h.push_back(H_row); beat_last.push_back(alpha_u_col_tlast);
      beat_hv.push_back(H_row_tvalid);
    end
    if (h_rd_en) begin haddr_log.push_back(int'(h_addr)); iter_log.push_back(int'(iter_idx)); end
    if (a_rd_en || h_rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    beat_cyc.delete(); beat_a.delete(); beat_h.delete(); beat_last.delete(); beat_hv.delete();
    haddr_log.delete(); iter_log.delete(); done_cnt = 0; rd_cnt = 0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk); start = 1'b1; iter_num = TW'(n);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, row_idx, iter_idx, h_rd_en, h_addr, a_rd_en, a_addr, H_row, H_row_tvalid,
         alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero busy=%b vld=%b row=%0d", busy, alpha_u_col_tvalid, row_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_row();
    bit ok; int bad = 0;
    clear_logs(); core_ready = 1'b1; auto_en = 1'b1;
    pulse_start(1);
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done_timeout: got no done, want done"); end
    checks++; if (beat_a.size() != 2*I) begin failures++; $display("FAIL single_beat_count: got %0d want %0d", beat_a.size(), 2*I); end
    else begin
      checks++; if (beat_a[0] !== a_mem[0]) begin failures++; $display("FAIL beat0_alpha: got %h want %h", beat_a[0], a_mem[0]); end
      checks++; if (beat_a[1] !== a_mem[1]) begin failures++; $display("FAIL beat1_alpha: got %h want %h", beat_a[1], a_mem[1]); end
      checks++; if (beat_h[0] !== 14'b01100010100011 || beat_h[1] !== 14'b01100010100011) begin
        failures++; $display("FAIL row0_hrow: got %b/%b want 01100010100011", beat_h[0], beat_h[1]); end
      checks++; if (beat_last[0] !== 1'b0 || beat_last[1] !== 1'b1) begin
        failures++; $display("FAIL row0_tlast: got %b%b want 01", beat_last[0], beat_last[1]); end
      for (int i = 0; i < 2*I; i++) begin
        if (beat_a[i] !== a_mem[i%2] || beat_h[i] !== h_mem[i/2] || beat_last[i] !== 1'(i%2) || beat_hv[i] !== 1'b1) bad++;
        if (i%2 == 1 && beat_cyc[i] != beat_cyc[i-1] + 1) bad++;
        if (i%2 == 0 && i > 0 && beat_cyc[i] == beat_cyc[i-1] + 1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL stream_contents: got %0d bad beats want 0", bad); end
    end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL single_end: got done_cnt=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_full_pass();
    bit ok; int bad = 0;
    clear_logs(); core_ready = 1'b1; auto_en = 1'b1;
    pulse_start(3);
    wait_done(1500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_done_timeout: got no done, want done"); end
    checks++; if (haddr_log.size() != 3*I) begin failures++; $display("FAIL full_rows: got %0d want %0d", haddr_log.size(), 3*I); end
    else begin
      for (int i = 0; i < 3*I; i++) if (haddr_log[i] != i%I || iter_log[i] != i/I) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL full_seq: got %0d bad addr/iter entries want 0", bad); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_ready_gate();
    bit ok; int c0;
    clear_logs(); core_ready = 1'b0; auto_en = 1'b1;
    pulse_start(1);
    repeat (10) @(negedge clk);
    checks++; if (rd_cnt != 0 || beat_a.size() != 0 || busy !== 1'b1) begin
      failures++; $display("FAIL gate_hold: got reads=%0d beats=%0d busy=%b want 0/0/1", rd_cnt, beat_a.size(), busy); end
    core_ready = 1'b1; c0 = cyc;
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL gate_done_timeout: got no done, want done"); end
    checks++; if (beat_cyc.size() == 0 || beat_cyc[0] != c0 + 3) begin
      failures++; $display("FAIL gate_latency: got first beat at +%0d want +3", beat_cyc.size() ? beat_cyc[0] - c0 : -1); end
  endtask

  task automatic test_spurious();
    bit ok; int n = 0, bad = 0;
    clear_logs(); core_ready = 1'b1; auto_en = 1'b1;
    pulse_start(0);
    while (!a_rd_en && n < 50) begin @(negedge clk); n++; end
    checks++; if (!a_rd_en) begin failures++; $display("FAIL spur_fetch: got no fetch, want fetch"); end
    man_done = 1'b1; start = 1'b1; iter_num = TW'(5);
    @(negedge clk); man_done = 1'b0; start = 1'b0;
    wait_done(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL spur_done_timeout: got no done, want done"); end
    checks++; if (haddr_log.size() != I) begin failures++; $display("FAIL spur_rows: got %0d want %0d", haddr_log.size(), I); end
    else begin
      for (int i = 0; i < I; i++) if (haddr_log[i] != i) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL spur_seq: got %0d bad addrs want 0", bad); end
    end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL spur_end: got done_cnt=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    int n = 0; bit ok;
    clear_logs(); core_ready = 1'b1; auto_en = 1'b1;
    pulse_start(1);
    while (!done && n < 400) begin @(negedge clk); n++; end
    checks++; if (!done) begin failures++; $display("FAIL b2b_done_timeout: got no done, want done"); end
    start = 1'b1; iter_num = TW'(1);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_start_in_done: got busy=%b done=%b want 0/0", busy, done); end
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
    clear_logs();
    wait_done(400, ok);
    checks++; if (!ok || haddr_log.size() != I) begin
      failures++; $display("FAIL b2b_second_pass: got done=%b rows=%0d want 1/%0d", ok, haddr_log.size(), I); end
  endtask

  task automatic test_abort();
    int n = 0; bit ok;
    clear_logs(); core_ready = 1'b1; auto_en = 1'b1;
    pulse_start(1);
    while (!(alpha_u_col_tvalid && alpha_u_col_tlast && row_idx == IW'(3)) && n < 400) begin @(negedge clk); n++; end
    checks++; if (!(alpha_u_col_tvalid && row_idx == IW'(3))) begin
      failures++; $display("FAIL abort_reach: got row=%0d vld=%b want row 3 beat", row_idx, alpha_u_col_tvalid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, row_idx, iter_idx, h_rd_en, a_rd_en, H_row_tvalid, alpha_u_col_tvalid,
                   alpha_u_col_tlast, H_row, alpha_u_col} !== '0) begin
      failures++; $display("FAIL abort_async: got busy=%b vld=%b row=%0d want all 0", busy, alpha_u_col_tvalid, row_idx); end
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_after: got done_cnt=%0d busy=%b want 0/0", done_cnt, busy); end
    clear_logs();
    pulse_start(1);
    wait_done(400, ok);
    checks++; if (!ok || haddr_log.size() != I || haddr_log[0] != 0) begin
      failures++; $display("FAIL abort_rerun: got done=%b rows=%0d want 1/%0d from row 0", ok, haddr_log.size(), I); end
  endtask

  initial begin
    h_mem[0] = 14'b01100010100011; h_mem[1] = 14'h3A5C; h_mem[2] = 14'h0F0F; h_mem[3] = 14'h2AAA;
    h_mem[4] = 14'h1555; h_mem[5] = 14'h3FFF; h_mem[6] = 14'h0001;
    a_mem[0] = 112'h74CEB3E7BFCE161B510533F9A6FF;
    a_mem[1] = 112'h8B324D194132E9E5AEFBCD065A01;
    test_reset();
    test_single_row();
    test_full_pass();
    test_ready_gate();
    test_spurious();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cal_core_sched.md
Name: cal_core_sched

Overview:
- Sequencer that drives one cal_core instance through a full decode pass.
- For each of I check rows it fetches the J-bit H row from H memory and the A alpha column words from alpha memory, then streams them to cal_core in the H_row/alpha_u_col stream format.
- It waits for cal_core to finish each row before issuing the next, and repeats the I-row sweep for a programmable number of iterations.
- Sits between the parameter/message memories and cal_core, under the top-level decode controller.

Parameters:
- J, 14, variable nodes per row (H_row width; alpha word = J*8 bits)
- I, 7, check rows per iteration
- A, 2, alphabet size = alpha beats per row
- MAX_ITER, 15, largest legal iteration count
- I_WIDTH, $clog2(I)+1, row index width (derived)
- A_WIDTH, $clog2(A)+1, beat index width (derived)
- IT_WIDTH, $clog2(MAX_ITER)+1, iteration counter width (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass when idle
- iter_num  in  IT_WIDTH  iteration count, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at pass end
- row_idx  out  I_WIDTH  current row
- iter_idx  out  IT_WIDTH  current iteration
- h_rd_en  out  1  H memory read strobe
- h_addr  out  I_WIDTH  H memory address (= row)
- h_rdata  in  J  H row; valid 1 cycle after h_rd_en
- a_rd_en  out  1  alpha memory read strobe
- a_addr  out  A_WIDTH  alpha beat address
- a_rdata  in  J*8  alpha word; valid 1 cycle after a_rd_en
- core_ready  in  1  cal_core idle, may accept a row
- core_done  in  1  one-cycle pulse, cal_core finished a row
- H_row  out  J  row mask to cal_core
- H_row_tvalid  out  1  H_row valid
- alpha_u_col  out  J*8  alpha beat to cal_core
- alpha_u_col_tvalid  out  1  alpha beat valid
- alpha_u_col_tlast  out  1  last beat of row

Behaviour:
- Reset (async, rst_n low): every output is 0, the state machine is in IDLE, and all counters are 0.
- Stream outputs are registered. On the edge after rdata is valid, rdata is loaded into H_row/alpha_u_col. Read issue to tvalid latency is therefore 2 cycles.
- State machine:
  - IDLE: on start, latch iter_num (a value of 0 is treated as 1; values above MAX_ITER saturate to MAX_ITER), set busy=1, clear row/iter, go to WAIT_RDY.
  - WAIT_RDY: when core_ready=1, go to FETCH.
  - FETCH: lasts exactly A cycles with beat counter k=0..A-1.
    - Each cycle asserts a_rd_en with a_addr=k.
    - h_rd_en with h_addr=row is asserted on k=0 only.
    - After the last cycle, go to DRAIN.
  - DRAIN: wait until the last beat has been presented, then go to WAIT_DONE.
  - WAIT_DONE: on core_done, advance row.
    - If row==I-1: row wraps to 0 and iter increments.
    - If iter was the last iteration: pulse done, clear busy, go to IDLE.
    - Otherwise go to WAIT_RDY.
- Beat stream:
  - The A beats appear on A consecutive cycles with alpha_u_col_tvalid=1.
  - H_row_tvalid=1 and H_row held constant for all A beats.
  - alpha_u_col_tlast=1 on beat A-1 only.
  - All valids drop to 0 the cycle after the last beat.
  - If A=1, the single beat carries tlast.
  - cal_core has no backpressure mid-row; core_ready gates whole rows only.
- H_row/alpha_u_col hold their last values when tvalid is low. The bench checks them only while tvalid=1.
- Simultaneous and edge events:
  - start while busy is ignored.
  - core_done outside WAIT_DONE is ignored and not counted.
  - core_ready falling during FETCH/DRAIN does not stall the row.
  - done and busy fall on the same edge; a start in the done cycle is ignored, and a start the next cycle is accepted.
  - rst_n asserted mid-pass aborts immediately: no done pulse, and valids are forced to 0 asynchronously.
- row_idx/iter_idx reflect the row currently being issued or awaited.

Test Plan:
1. Single row, single iteration (I=7, A=2, iter_num=1): H mem[0]=14'b01100010100011, alpha mem[0]=0x74CEB3E7BFCE161B5105 33F9A6FF, alpha mem[1]=0x8B324D194132E9E5AEFBCD065A01. Start -> two consecutive beats carry those words; H_row=14'b01100010100011 on both; tlast on the 2nd beat only. After 7 core_done pulses, done pulses once and busy=0.
2. Full pass iter_num=3 -> exactly 21 rows issued; h_addr sequence 0..6 repeated 3 times; iter_idx steps 0,1,2; exactly one done.
3. core_ready held low for 10 cycles after start -> no reads and no valids until core_ready rises; first tvalid appears 3 cycles after the rise (1 cycle WAIT_RDY to FETCH + 2 cycles read latency).
4. Spurious core_done during FETCH, a start pulse while busy, and iter_num=0 -> no extra row advance, no restart, exactly one iteration (7 rows) executed.
5. rst_n pulled low during the second beat of row 3 -> all outputs 0 immediately; after release no done pulse and busy=0; a new start runs normally from row 0.
